// File: rtl/triangle_osc.sv
// Handshaked phase-accumulator oscillator: triangle / sawtooth / square / silence,
// scaled by a saturating Q1.7 gain. Pitch, shape and gain changes land only on a phase wrap.
module triangle_osc #(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic        [phase_width_p-1:0] phase_inc_i,
    input  logic        [1:0]               mode_i,
    input  logic        [7:0]               gain_i,
    input  logic                            sync_i,
    input  logic                            ready_i,
    output logic signed [width_p-1:0]       data_o,
    output logic                            valid_o
);

    localparam int prod_w = width_p + 9;

    localparam logic [1:0] mode_tri = 2'd0;
    localparam logic [1:0] mode_saw = 2'd1;
    localparam logic [1:0] mode_sqr = 2'd2;

    localparam logic signed [prod_w-1:0] sat_max = {{10{1'b0}}, {(width_p-1){1'b1}}};
    localparam logic signed [prod_w-1:0] sat_min = {{10{1'b1}}, {(width_p-1){1'b0}}};

    // Signed shape times unsigned Q1.7 gain, floor-shifted back to unity and clamped.
    function automatic logic signed [width_p-1:0] gain_sat(
        input logic signed [width_p-1:0] s,
        input logic        [7:0]         g
    );
        logic signed [prod_w-1:0] a;
        logic signed [prod_w-1:0] b;
        logic signed [prod_w-1:0] prod;
        logic signed [prod_w-1:0] shifted;
        a       = {{9{s[width_p-1]}}, s};
        b       = {{(width_p+1){1'b0}}, g};
        prod    = a * b;
        shifted = prod >>> 7;
        if (shifted > sat_max) begin
            return sat_max[width_p-1:0];
        end else if (shifted < sat_min) begin
            return sat_min[width_p-1:0];
        end
        return shifted[width_p-1:0];
    endfunction

    logic [phase_width_p-1:0] phase_r;
    logic [phase_width_p-1:0] inc_q;
    logic [1:0]               mode_q;
    logic [7:0]               gain_q;
    logic                     prime_r;

    logic                     accept;
    logic [phase_width_p:0]   sum;
    logic                     wrap;
    logic [phase_width_p-1:0] phase_n;
    logic [phase_width_p-1:0] inc_n;
    logic [1:0]               mode_n;
    logic [7:0]               gain_n;

    always_comb begin
        accept  = valid_o & ready_i;
        sum     = {1'b0, phase_r} + {1'b0, inc_q};
        wrap    = sync_i | sum[phase_width_p];
        phase_n = sync_i ? '0 : sum[phase_width_p-1:0];
        inc_n   = wrap ? phase_inc_i : inc_q;
        mode_n  = wrap ? mode_i : mode_q;
        gain_n  = wrap ? gain_i : gain_q;
    end

    // The priming sample is taken at phase 0 with the parameters latched during reset.
    logic [width_p:0]         shape_top;
    logic [1:0]               shape_mode;
    logic [7:0]               shape_gain;
    logic [width_p-1:0]       tri_v;
    logic [width_p-1:0]       saw_v;
    logic signed [width_p-1:0] shape_v;
    logic signed [width_p-1:0] sample_n;

    always_comb begin
        shape_top  = prime_r ? '0 : phase_n[phase_width_p-1:phase_width_p-width_p-1];
        shape_mode = prime_r ? mode_q : mode_n;
        shape_gain = prime_r ? gain_q : gain_n;

        tri_v          = shape_top[width_p] ? ~shape_top[width_p-1:0] : shape_top[width_p-1:0];
        tri_v[width_p-1] = ~tri_v[width_p-1];
        saw_v          = shape_top[width_p:1];
        saw_v[width_p-1] = ~saw_v[width_p-1];

        case (shape_mode)
            mode_tri: shape_v = tri_v;
            mode_saw: shape_v = saw_v;
            mode_sqr: shape_v = shape_top[width_p] ? {1'b0, {(width_p-1){1'b1}}}
                                                   : {1'b1, {(width_p-1){1'b0}}};
            default:  shape_v = '0;
        endcase

        sample_n = gain_sat(shape_v, shape_gain);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_r <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            prime_r <= 1'b1;
            inc_q   <= phase_inc_i;
            mode_q  <= mode_i;
            gain_q  <= gain_i;
        end else if (prime_r) begin
            data_o  <= sample_n;
            valid_o <= 1'b1;
            prime_r <= 1'b0;
        end else if (accept) begin
            phase_r <= phase_n;
            inc_q   <= inc_n;
            mode_q  <= mode_n;
            gain_q  <= gain_n;
            data_o  <= sample_n;
        end
    end

endmodule

// File: tb/tb_triangle_osc.sv
// Bench for triangle_osc: directed vector table, then randomized run against an integer model.
module tb_triangle_osc;

    localparam int W = 12;
    localparam int P = 24;
    localparam longint FULL = 64'd1 << P;
    localparam longint HALF = 64'd1 << (P - 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                sync;
    logic                ready;
    logic [P-1:0]        inc;
    logic [1:0]          mode;
    logic [7:0]          gain;
    logic signed [W-1:0] data;
    logic                valid;

    always #5 clk = ~clk;

    triangle_osc #(.width_p(W), .phase_width_p(P)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .phase_inc_i(inc),
        .mode_i     (mode),
        .gain_i     (gain),
        .sync_i     (sync),
        .ready_i    (ready),
        .data_o     (data),
        .valid_o    (valid)
    );

    typedef struct {
        bit           rst;
        bit           rdy;
        bit           sy;
        logic [1:0]   mode;
        logic [P-1:0] inc;
        logic [7:0]   gain;
        bit           exp_valid;
        int           exp_data;
    } vec_t;

    vec_t         vecs[$];
    logic [1:0]   cur_mode;
    logic [P-1:0] cur_inc;
    logic [7:0]   cur_gain;

    int n_err = 0;
    int n_chk = 0;

    function automatic void add(input bit r, input bit rdy, input bit sy, input bit ev, input int ed);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.sy = sy;
        v.mode = cur_mode; v.inc = cur_inc; v.gain = cur_gain;
        v.exp_valid = ev; v.exp_data = ed;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference model: plain integer arithmetic on the phase value.
    longint m_phase, m_inc, m_data;
    int     m_mode, m_gain;
    bit     m_valid, m_prime;

    function automatic longint ref_sample(input longint p, input int m, input int g);
        longint s, v;
        case (m)
            0: s = ((p < HALF) ? p : (FULL - 1 - p)) / (64'd1 << (P - W - 1)) - 2048;
            1: s = p / (64'd1 << (P - W)) - 2048;
            2: s = (p >= HALF) ? 2047 : -2048;
            default: s = 0;
        endcase
        v = s * g;
        if (v >= 0) v = v / 128;
        else        v = -((-v + 127) / 128);
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    function automatic void model_step(input bit r, input bit rdy, input bit sy,
                                       input longint i, input int m, input int g);
        longint s;
        bit     wr;
        if (r) begin
            m_phase = 0; m_data = 0; m_valid = 0; m_prime = 1;
            m_inc = i; m_mode = m; m_gain = g;
        end else if (m_prime) begin
            m_data = ref_sample(0, m_mode, m_gain);
            m_valid = 1; m_prime = 0;
        end else if (m_valid && rdy) begin
            s  = m_phase + m_inc;
            wr = sy || (s >= FULL);
            m_phase = sy ? 0 : (s % FULL);
            if (wr) begin
                m_inc = i; m_mode = m; m_gain = g;
            end
            m_data = ref_sample(m_phase, m_mode, m_gain);
        end
    endfunction

    int tri_a[4]  = '{-1536, -1024, -512, 0};
    int tri_b[13] = '{512, 1024, 1536, 2047, 1535, 1023, 511, -1, -513, -1025, -1537, -2048, -1536};

    initial begin
        reset = 1'b1; sync = 1'b0; ready = 1'b0;
        inc = '0; mode = '0; gain = 8'd128;

        // Triangle, unity gain, period 16, with a 5-cycle stall (one stalled sync).
        cur_mode = 2'd0; cur_inc = 24'h100000; cur_gain = 8'd128;
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 1, -2048);
        foreach (tri_a[k]) add(0, 1, 0, 1, tri_a[k]);
        for (int k = 0; k < 5; k++) add(0, 0, (k == 2), 1, 0);
        foreach (tri_b[k]) add(0, 1, 0, 1, tri_b[k]);

        // Square with saturating gain, gain change deferred to the wrap.
        cur_mode = 2'd2; cur_inc = 24'h800000; cur_gain = 8'd255;
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 1, -2048);
        add(0, 1, 0, 1, 2047);
        add(0, 1, 0, 1, -2048);
        cur_gain = 8'd64;
        add(0, 1, 0, 1, 2047);
        add(0, 1, 0, 1, -1024);
        add(0, 1, 0, 1, 1023);
        add(0, 1, 0, 1, -1024);

        // Sawtooth; inc/mode/gain change after the 5th sample, applied from the wrap.
        cur_mode = 2'd1; cur_inc = 24'h100000; cur_gain = 8'd128;
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 1, -2048);
        for (int k = 1; k <= 4; k++) add(0, 1, 0, 1, k * 256 - 2048);
        cur_mode = 2'd0; cur_inc = 24'h200000; cur_gain = 8'd64;
        for (int k = 5; k <= 15; k++) add(0, 1, 0, 1, k * 256 - 2048);
        add(0, 1, 0, 1, -1024);
        add(0, 1, 0, 1, -512);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 512);
        // Sync at phase 0x600000 reloads gain; sync while stalled is ignored.
        cur_gain = 8'd128;
        add(0, 1, 1, 1, -2048);
        add(0, 0, 1, 1, -2048);
        add(0, 1, 0, 1, -1024);

        // Mid-stream reset with ready high.
        add(0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 1, -2048);
        add(0, 1, 0, 1, -1024);

        // inc=0 holds DC; a gain change waits for a sync.
        cur_mode = 2'd1; cur_inc = '0; cur_gain = 8'd128;
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 1, -2048);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 1, -2048);
        cur_gain = 8'd64;
        add(0, 1, 0, 1, -2048);
        add(0, 1, 0, 1, -2048);
        add(0, 1, 1, 1, -1024);

        foreach (vecs[n]) begin
            reset = vecs[n].rst; ready = vecs[n].rdy; sync = vecs[n].sy;
            mode = vecs[n].mode; inc = vecs[n].inc; gain = vecs[n].gain;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", n), longint'(valid), longint'(vecs[n].exp_valid));
            check($sformatf("vec%0d data", n), longint'(data), longint'(vecs[n].exp_data));
        end

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 99) < 70);
            sync  = ($urandom_range(0, 99) < 4);
            if (c == 0 || $urandom_range(0, 4) == 0) begin
                inc  = ($urandom_range(0, 3) == 0) ? P'($urandom_range(0, 4095)) : P'($urandom());
                mode = 2'($urandom_range(0, 3));
                gain = 8'($urandom_range(0, 255));
            end
            model_step(reset, ready, sync, longint'(inc), int'(mode), int'(gain));
            @(posedge clk);
            #1;
            check($sformatf("rand%0d valid", c), longint'(valid), longint'(m_valid));
            check($sformatf("rand%0d data", c), longint'(data), m_data);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/triangle_osc.md
# triangle_osc

Runtime-programmable, handshaked oscillator for the synth voice path. A phase accumulator drives a selectable shape: triangle, sawtooth, square or silence. The shape is scaled by a saturating gain and delivered one sample per valid/ready transfer. Frequency is set by a phase increment rather than a build-time table depth, so one instance covers any pitch. Shape, pitch and gain changes are applied only at a phase wrap, which keeps note changes click-free.

## Interface
- width_p, 12: sample width; data_o is two's-complement signed.
- phase_width_p, 24: phase accumulator width; must be >= width_p + 1.
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- phase_inc_i  in  phase_width_p  unsigned phase step per accepted sample; f_out = f_s * inc / 2^phase_width_p.
- mode_i  in  2  shape select: 0 triangle, 1 sawtooth, 2 square, 3 silence.
- gain_i  in  8  unsigned Q1.7 gain; 128 = unity, 0 = mute, 255 ≈ 1.99.
- sync_i  in  1  hard resync request; sampled only on an accepted transfer.
- ready_i  in  1  downstream ready.
- data_o  out  width_p  current sample, signed.
- valid_o  out  1  data_o is valid.

## Operation
- State registers:
  - phase_r (phase_width_p bits)
  - latched parameters inc_q, mode_q, gain_q
  - output register data_o, valid_o
  - one-cycle prime flag
- Reset (reset_i=1 at a clock edge):
  - phase_r=0, data_o=0, valid_o=0.
  - inc_q, mode_q, gain_q load phase_inc_i, mode_i, gain_i.
- Prime: on the first edge with reset_i=0, data_o <= shape(0, mode_q, gain_q) and valid_o <= 1. valid_o then stays 1 until the next reset.
- Accept: an edge with valid_o=1 and ready_i=1.
  - phase_n = sync_i ? 0 : (phase_r + inc_q) mod 2^phase_width_p.
  - wrap = sync_i OR carry-out of that addition.
  - phase_r <= phase_n.
  - If wrap: inc_q, mode_q, gain_q reload from the inputs, and the new values are used for this sample.
  - data_o <= shape(phase_n, mode', gain'), where mode' and gain' are the post-reload values.
- No accept (ready_i=0): phase_r, data_o and the latched parameters all hold. Input changes have no effect until a wrapping accept.
- Shape, with P = phase_width_p, W = width_p, phase value p:
  - Triangle: f = p[P-1] ? ~p[P-2:0] : p[P-2:0]. Take t = f[P-2:P-W-1] and invert its MSB. The result runs -2^(W-1) at p=0 up to 2^(W-1)-1 at p=2^(P-1). It is asymmetric by one LSB on the falling half; this is accepted.
  - Sawtooth: p[P-1:P-W] with MSB inverted.
  - Square: p[P-1] ? 2^(W-1)-1 : -2^(W-1).
  - Silence: 0.
- Gain:
  - Product = signed shape × unsigned gain, kept at W+9 bits.
  - Arithmetic shift right by 7.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
- inc_q=0 holds the phase, giving DC at the phase-0 value. This is legal.

## Timing
- Reset values: data_o=0, valid_o=0.
- valid_o rises exactly one cycle after reset_i deasserts.
- Throughput: one sample per cycle while ready_i=1. There are no bubbles after prime.
- data_o and valid_o are registered; there is no combinational path from any input to any output.
- Parameter changes take effect on the first accept whose phase addition carries out, or on an accept with sync_i=1. That sample already uses the new mode and gain.
- Reset asserted mid-stream overrides everything on that edge. A simultaneous accept is discarded.
- sync_i together with ready_i=0 is ignored.

## Test plan
- W=12, P=24, inc=0x100000, triangle, gain=128, ready_i=1 -> prime value -2048, then -1536, -1024, -512, 0, 512, 1024, 1536, 2047, 1535, ..., repeating with period 16.
- Square, inc=0x800000, gain=255 -> alternating 2047 (saturated from 4077) and -2048 (saturated from -4080). The same run with gain=64 -> 1023 and -1024.
- Sawtooth, inc=0x100000; change phase_inc_i to 0x200000 at the 5th sample -> the step stays 256 through the wrap sample, then becomes 512. mode_i and gain_i changed mid-period likewise apply only from the wrap sample.
- Backpressure: drop ready_i for 5 cycles mid-stream -> data_o and the phase frozen, and no sample skipped or repeated once ready resumes.
- sync_i=1 on an accept at phase 0x600000 with triangle mode -> next data_o = -2048, with parameters reloaded. sync_i with ready_i=0 -> no effect.
- Assert reset_i for 1 cycle mid-stream with ready_i=1 -> data_o=0 and valid_o=0 on that edge, valid_o=1 with the phase-0 value on the next edge.
